// File: rtl/data_bus_lsu.sv
// ============================================================================
// Module      : data_bus_lsu
// Description : RV32I load/store unit bridging the datapath memory port onto an
//               APB-style data bus. Optional build macro LSU_MISALIGN_TRAP_EN
//               traps misaligned halfword/word accesses instead of aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        misalign,
    output logic        busy,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [3:0]  pstrb,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_paddr;
    logic [3:0]  r_pstrb;
    logic [31:0] r_pwdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_mis;

    logic        w_illegal;
    logic        w_misalign;
    logic        w_timeout;
    logic        w_enter_resp;
    logic        w_err_nxt;
    logic        w_mis_nxt;
    logic [3:0]  w_strb;
    logic [31:0] w_wlanes;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Stores only exist as SB/SH/SW, so a store with funct3[2] set is also illegal.
    assign w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (we && funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = !w_illegal &&
                        (((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_strb   = 4'b1111;
        w_wlanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_strb   = 4'b0001 << addr[1:0];
                w_wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_strb   = addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = prdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? prdata[31:16] : prdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = prdata;
        endcase
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset || (r_state != S_ACCESS) || pready) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_timeout = !pready && (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_resp = 1'b0;
        w_err_nxt    = 1'b0;
        w_mis_nxt    = 1'b0;
        psel         = 1'b0;
        penable      = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_illegal || w_misalign) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                        w_err_nxt    = 1'b1;
                        w_mis_nxt    = w_misalign;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                psel        = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                    w_err_nxt    = pslverr;
                end else if (w_timeout) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                    w_err_nxt    = 1'b1;
                end
            end
            default: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
            r_paddr  <= 32'd0;
            r_pstrb  <= 4'd0;
            r_pwdata <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && req) begin
                r_we     <= we;
                r_funct3 <= funct3;
                r_lane   <= addr[1:0];
                r_paddr  <= {addr[31:2], 2'b00};
                r_pstrb  <= we ? w_strb : 4'd0;
                r_pwdata <= we ? w_wlanes : 32'd0;
            end
            // Load data only changes on completion so it holds between done pulses.
            if (w_enter_resp) begin
                r_err   <= w_err_nxt;
                r_mis   <= w_mis_nxt;
                r_rdata <= (w_err_nxt || r_we) ? 32'd0 : w_load;
            end
        end
    end

    assign rdata    = r_rdata;
    assign err      = r_err;
    assign misalign = r_mis;
    assign busy     = (r_state != S_IDLE);
    assign paddr    = r_paddr;
    assign pwrite   = r_we;
    assign pstrb    = r_pstrb;
    assign pwdata   = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_data_bus_lsu.sv
// ============================================================================
// Module      : tb_data_bus_lsu
// Description : Scoreboard bench for data_bus_lsu with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_bus_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        misalign;
    logic        busy;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata = 32'd0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    typedef struct {
        logic        err;
        logic        mis;
        logic        chk_rd;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic psel_seen = 1'b0;

    data_bus_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
        .misalign(misalign), .busy(busy), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (psel) psel_seen = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                    if (e.chk_rd) chk("rdata", rdata, e.rd);
                end
            end
        end
    end

    task automatic run(input string nm, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pd,
                       input int waits, input logic slverr, input logic bus,
                       input logic [3:0] strb, input logic [31:0] pwd,
                       input logic eerr, input logic emis, input logic chkrd,
                       input logic [31:0] erd, input int lat, input logic hold);
        int b;
        @(posedge clk); #1;
        req = 1'b1; we = wr; funct3 = f3; addr = a; wdata = wd;
        q.push_back('{eerr, emis, chkrd, erd, cyc + lat});
        psel_seen = 1'b0;
        @(posedge clk); #1;
        if (hold) funct3 = 3'b011;
        else req = 1'b0;
        prdata = pd; pslverr = slverr; pready = 1'b0;
        if (bus) begin
            @(negedge clk);
            chk({nm, "_setup_psel"}, {31'd0, psel}, 32'd1);
            chk({nm, "_setup_penable"}, {31'd0, penable}, 32'd0);
            chk({nm, "_paddr"}, paddr, {a[31:2], 2'b00});
            chk({nm, "_pstrb"}, {28'd0, pstrb}, {28'd0, strb});
            chk({nm, "_pwrite"}, {31'd0, pwrite}, {31'd0, wr});
            if (wr) chk({nm, "_pwdata"}, pwdata, pwd);
        end
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            pready = (k == waits);
            if (bus && k == 0) begin
                @(negedge clk);
                chk({nm, "_access_penable"}, {31'd0, penable}, 32'd1);
                chk({nm, "_access_paddr"}, paddr, {a[31:2], 2'b00});
            end
        end
        @(posedge clk); #1;
        pready = 1'b0;
        b = 0;
        @(negedge clk);
        while (busy && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) chk({nm, "_busy_timeout"}, 32'd1, 32'd0);
        req = 1'b0;
        if (!bus) chk({nm, "_no_psel"}, {31'd0, psel_seen}, 32'd0);
        if (hold) begin
            @(negedge clk);
            @(negedge clk);
            chk({nm, "_ignored_req"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {done, err, misalign, busy, psel, penable, pwrite, 25'd0},
            32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pstrb_pwdata", {28'd0, pstrb} | pwdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        //   name    we  f3      addr          wdata         prdata        w  slv bus strb    pwdata        err mis chk  rdata         lat hold
        run("sw",    1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 32'h0,        3, 0);
        run("sb",    1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 1, 4'b1000, 32'hA5A5A5A5, 0, 0, 0, 32'h0,        3, 0);
        run("sh",    1, 3'b001, 32'h102, 32'h00001234, 32'h0,        0, 0, 1, 4'b1100, 32'h12341234, 0, 0, 0, 32'h0,        3, 0);
        run("lb",    0, 3'b000, 32'h102, 32'h0,        32'h1280FF00, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'hFFFFFF80, 3, 0);
        run("lbu",   0, 3'b100, 32'h102, 32'h0,        32'h1280FF00, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'h00000080, 3, 0);
        run("lh",    0, 3'b001, 32'h102, 32'h0,        32'h1280FF00, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'h00001280, 3, 0);
        run("lhu",   0, 3'b101, 32'h100, 32'h0,        32'h1280FF00, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'h0000FF00, 3, 0);
        run("lb1",   0, 3'b000, 32'h101, 32'h0,        32'h1280FF00, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 3, 0);
        run("lbu3",  0, 3'b100, 32'h103, 32'h0,        32'h1280FF00, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'h00000012, 3, 0);
        run("lw_ws", 0, 3'b010, 32'h200, 32'h0,        32'hCAFEF00D, 2, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'hCAFEF00D, 5, 0);
        run("tmo",   0, 3'b010, 32'h300, 32'h0,        32'h11111111, 10, 0, 1, 4'b0000, 32'h0,       1, 0, 1, 32'h0,        6, 0);
        run("slverr",0, 3'b010, 32'h300, 32'h0,        32'h22222222, 0, 1, 1, 4'b0000, 32'h0,        1, 0, 1, 32'h0,        3, 0);
        run("f3_011",0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 0, 1, 32'h0,        1, 0);
        run("f3_110",0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        1, 0, 1, 32'h0,        1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        run("lw_mis",0, 3'b010, 32'h101, 32'h0,        32'h33333333, 0, 0, 0, 4'b0000, 32'h0,        1, 1, 1, 32'h0,        1, 0);
`else
        run("lw_mis",0, 3'b010, 32'h101, 32'h0,        32'h33333333, 0, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'h33333333, 3, 0);
`endif
        run("hold",  0, 3'b010, 32'h400, 32'h0,        32'h44444444, 1, 0, 1, 4'b0000, 32'h0,        0, 0, 1, 32'h44444444, 4, 1);

        // Reset asserted mid-access: bus drops at that edge and no done follows.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        req = 1'b0; pready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_penable_before", {31'd0, penable}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_bus", {29'd0, psel, penable, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
